// File: rtl/run_monitor_pkg.sv
// Shared types and constants for the run-control / performance monitor.
package run_monitor_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam logic [1:0] CAUSE_NONE  = 2'b00;
  localparam logic [1:0] CAUSE_HALT  = 2'b01;
  localparam logic [1:0] CAUSE_LIMIT = 2'b10;

  // Width of a down-counter that must hold the value n (at least one bit).
  function automatic int drainWidth(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/run_monitor_sat_counter.sv
// Saturating up-counter: sticks at all-ones instead of wrapping.
module sat_counter
  import run_monitor_pkg::*;
#(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  localparam logic [W-1:0] SAT_MAX = '1;

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != SAT_MAX)) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign q = count_q;

endmodule

// File: rtl/run_monitor.sv
// Run-control block: counts cycles/retires/stalls, stops the pipeline on HALT
// (after a drain window) or on cycle-budget overrun, and reports why.
module run_monitor
  import run_monitor_pkg::*;
#(
  parameter int unsigned          CNT_W        = 16,
  parameter int unsigned          OPC_W        = 7,
  parameter logic [OPC_W-1:0]     HALT_OPCODE  = 7'h7F,
  parameter int unsigned          MAX_CYCLES   = 60,
  parameter int unsigned          DRAIN_CYCLES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             retire_valid,
  input  logic [OPC_W-1:0] retire_opcode,
  input  logic             stall,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] instr_count,
  output logic [CNT_W-1:0] stall_count,
  output logic             halt_req,
  output logic             done,
  output logic [1:0]       done_cause
);

  localparam int             DRAIN_W = drainWidth(DRAIN_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e             state_q, state_d;
  logic [DRAIN_W-1:0] drain_q, drain_d;
  logic [1:0]         cause_q, cause_d;

  logic             cycInc;
  logic             instrInc;
  logic             stallInc;
  logic [CNT_W-1:0] cycNext;
  logic             limitHit;
  logic             haltRetire;

  // Retires and stalls seen during DRAIN are wrong-path and not counted.
  assign cycInc   = (state_q != ST_DONE);
  assign instrInc = (state_q == ST_RUN) && retire_valid;
  assign stallInc = (state_q == ST_RUN) && stall;

  // The budget is compared against the value cycle_count is about to take.
  assign cycNext    = (cycle_count == CNT_MAX) ? cycle_count : cycle_count + CNT_W'(1);
  assign limitHit   = (MAX_CYCLES != 0) && (32'(cycNext) == MAX_CYCLES);
  assign haltRetire = retire_valid && (retire_opcode == HALT_OPCODE);

  sat_counter #(.W(CNT_W)) u_cycleCnt (
    .clk   (clk),
    .reset (reset),
    .clr   (1'b0),
    .inc   (cycInc),
    .q     (cycle_count)
  );

  sat_counter #(.W(CNT_W)) u_instrCnt (
    .clk   (clk),
    .reset (reset),
    .clr   (1'b0),
    .inc   (instrInc),
    .q     (instr_count)
  );

  sat_counter #(.W(CNT_W)) u_stallCnt (
    .clk   (clk),
    .reset (reset),
    .clr   (1'b0),
    .inc   (stallInc),
    .q     (stall_count)
  );

  // Limit check outranks HALT in both active states.
  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    cause_d = cause_q;
    unique case (state_q)
      ST_RUN: begin
        if (limitHit) begin
          state_d = ST_DONE;
          cause_d = CAUSE_LIMIT;
        end else if (haltRetire) begin
          if (DRAIN_CYCLES == 0) begin
            state_d = ST_DONE;
            cause_d = CAUSE_HALT;
          end else begin
            state_d = ST_DRAIN;
            drain_d = DRAIN_W'(DRAIN_CYCLES);
          end
        end
      end
      ST_DRAIN: begin
        if (limitHit) begin
          state_d = ST_DONE;
          cause_d = CAUSE_LIMIT;
        end else if (drain_q == DRAIN_W'(1)) begin
          state_d = ST_DONE;
          cause_d = CAUSE_HALT;
        end else begin
          drain_d = drain_q - DRAIN_W'(1);
        end
      end
      ST_DONE: begin
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_RUN;
      drain_q <= '0;
      cause_q <= CAUSE_NONE;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      cause_q <= cause_d;
    end
  end

  assign halt_req   = (state_q != ST_RUN);
  assign done       = (state_q == ST_DONE);
  assign done_cause = cause_q;

endmodule
